keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Debounced 4x4 matrix-keypad scanner that consumes the divided scan clock produced by the clock divider. It drives one keypad column at a time and samples the rows. It reports each new keypress exactly once as a 4-bit hex code with a one-cycle valid pulse, for the display/digit-shift logic downstream. All logic runs on the fast `clk`. `scan_clk` is used only as an edge-detected enable, never as a clock.

## Interface
- `DEBOUNCE_TICKS`, default 4: number of consecutive scan ticks a row level must hold to count as pressed or released. Legal range 2..15.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low.
- `scan_clk`  in  1  divided clock from the divider; same clock domain, registered.
- `rows`  in  4  keypad rows, active-low (pulled up), asynchronous.
- `cols`  out  4  column drive, active-low one-hot.
- `key_code`  out  4  hex code of the last accepted key.
- `key_valid`  out  1  one-`clk` pulse when `key_code` is updated.
- `key_held`  out  1  high while an accepted key is still pressed.

## Operation
- **Tick generation.** `scan_tick` = (`scan_clk` != `scan_prev`), so both edges count. `scan_prev` resets to 0.
- **Row synchronizer.** `rows` passes through a 2-flop synchronizer that resets to 4'b1111. All decisions use the synchronized value `rows_s`. A row is pressed when its bit is 0.
- **Key map** (row r, column c), row-major:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **FSM states:** SCAN, DEBOUNCE, HELD, RELEASE. Outside a tick the FSM holds its state.
- **SCAN**
  - On a tick with `rows_s` == 4'b1111: advance the active column c0→c1→c2→c3→c0.
  - On a tick with any row low: latch the current column, and the lowest-index low row (multiple rows means the lowest index wins). Set cnt=1, go to DEBOUNCE. `cols` does not advance.
- **DEBOUNCE** (`cols` frozen)
  - On a tick with the latched row still low: cnt+1.
  - When cnt reaches `DEBOUNCE_TICKS`: load `key_code`, pulse `key_valid`, go to HELD.
  - On a tick with the latched row high: go to SCAN, advance the column, no output.
- **HELD** (`cols` frozen, `key_held`=1)
  - Only the latched row is observed. Other keys are ignored: no rollover, no second code.
  - On a tick with the latched row high: set cnt=1, go to RELEASE.
- **RELEASE** (`cols` frozen, `key_held`=1)
  - On a tick with the latched row high: cnt+1. When cnt reaches `DEBOUNCE_TICKS`: go to SCAN, advance the column, `key_held`=0.
  - On a tick with the latched row low (bounce): go to HELD with no new `key_valid`.
- **Counter width:** cnt is 4 bits and never exceeds `DEBOUNCE_TICKS`.
- **Reset** (synchronous, while `reset`=0; this overrides everything, including mid-debounce and while held):
  - state=SCAN, `cols`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, cnt=0, `scan_prev`=0, row synchronizer=4'b1111.
  - No `key_valid` is emitted for a key pressed across reset; it must be re-debounced from SCAN.

## Timing
- `cols` changes 1 `clk` after the tick that advances it (registered).
- `rows_s` reflects a pad change 2 `clk` later.
- Ticks must be ≥4 `clk` apart, so a column's rows settle before the next sample. This is satisfied by any divider `num_cycles` ≥ 3.
- Press latency: the detection tick counts as sample 1. `key_valid` is high in the `clk` cycle after the tick on which cnt reaches `DEBOUNCE_TICKS`. This is `DEBOUNCE_TICKS`-1 ticks after detection, plus 1 `clk`.
- `key_valid` is exactly 1 `clk` wide. `key_code` changes in the same cycle and then holds until the next accepted key.
- `key_held` rises with `key_valid`. It falls 1 `clk` after the tick that completes the release count.
- Minimum time between two accepted keys is 2·`DEBOUNCE_TICKS` ticks.

## Test plan
DEBOUNCE_TICKS=4; `scan_clk` toggles every 8 `clk` (tick every 8 `clk`).
1. **Reset, idle.** Hold `reset`=0 for 3 cycles, then release with `rows`=1111. Expect `cols` at 1110 → 1101 → 1011 → 0111 → 1110 on successive ticks, and `key_valid` never asserted.
2. **Clean press of "5".** Hold `rows`=1101 while `cols`=1101 for 6 ticks. Expect `cols` frozen at 1101, one `key_valid` pulse with `key_code`=4'h5 1 `clk` after the 4th sampled tick, and `key_held`=1.
3. **Bounce rejection.** Hold row0 low while on col3 for 2 ticks, then release. Expect no `key_valid`, return to SCAN, and `cols` advancing to 1110.
4. **Held/release bounce.** After accepting "D" (row3, col3), release for 2 ticks, press again for 3 ticks, then release for 4 ticks. Expect exactly one `key_valid` in total, and `key_held` staying 1 until 1 `clk` after the 4th release tick.
5. **Multi-key.** With row1 and row2 low together on col0, expect `key_code`=4'h4. While that key is held, press "9". Expect no additional `key_valid`.
6. **Reset mid-debounce.** Assert `reset` after 2 debounce ticks with the key still down. Expect all outputs at their reset values. After release of `reset`, expect a fresh full 4-tick debounce before a single `key_valid`.

Source files
------------

// File: rtl/keypad_scanner.sv
// Debounced 4x4 keypad scanner; walks one active-low column per scan tick
// and reports each accepted key once as a hex code with a one-cycle pulse.
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_clk,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam logic [3:0] LAST = 4'(DEBOUNCE_TICKS);

    state_t     state;
    logic       scan_prev;
    logic       scan_tick;
    logic [3:0] rows_m;
    logic [3:0] rows_s;
    logic [1:0] col;
    logic [1:0] row;
    logic [1:0] first_row;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       row_low;

    assign scan_tick = scan_clk != scan_prev;
    assign row_low   = ~rows_s[row];
    assign cnt_next  = cnt + 4'd1;

    // lowest-index pressed row wins when several are low
    always_comb begin
        first_row = 2'd0;
        priority case (1'b1)
            !rows_s[0]: first_row = 2'd0;
            !rows_s[1]: first_row = 2'd1;
            !rows_s[2]: first_row = 2'd2;
            !rows_s[3]: first_row = 2'd3;
            default:    first_row = 2'd0;
        endcase
    end

    function automatic logic [3:0] keymap(input logic [1:0] r,
                                          input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            scan_prev <= 1'b0;
            rows_m    <= 4'b1111;
            rows_s    <= 4'b1111;
            col       <= 2'd0;
            cols      <= 4'b1110;
            row       <= 2'd0;
            cnt       <= 4'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            scan_prev <= scan_clk;
            rows_m    <= rows;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            if (scan_tick) begin
                unique case (state)
                    SCAN: begin
                        if (rows_s == 4'b1111) begin
                            col  <= col + 2'd1;
                            cols <= {cols[2:0], cols[3]};
                        end else begin
                            row   <= first_row;
                            cnt   <= 4'd1;
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (row_low) begin
                            cnt <= cnt_next;
                            if (cnt_next == LAST) begin
                                key_code  <= keymap(row, col);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end
                        end else begin
                            col   <= col + 2'd1;
                            cols  <= {cols[2:0], cols[3]};
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!row_low) begin
                            cnt   <= 4'd1;
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (row_low) begin
                            state <= HELD;
                        end else begin
                            cnt <= cnt_next;
                            if (cnt_next == LAST) begin
                                key_held <= 1'b0;
                                col      <= col + 2'd1;
                                cols     <= {cols[2:0], cols[3]};
                                state    <= SCAN;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized keypad bench: a virtual pad drives the rows, a tick-level
// reference model predicts accepted keys into a scoreboard queue.
module tb_keypad_scanner;

    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_clk;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pad;

    int n_chk  = 0;
    int n_fail = 0;

    int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int mode;
    int mcol;
    int mrow;
    int mcnt;
    int mcode;
    int q[$];

    keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk(clk),
        .reset(reset),
        .scan_clk(scan_clk),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!cols[c] && pad[r*4+c]) rows[r] = 1'b0;
    end

    function automatic void check(input string name, input int act,
                                  input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid !== 1'b0) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: key_valid=%b code=%0d at %0t",
                         key_valid, key_code, $time);
            end else begin
                int e;
                e = q.pop_front();
                n_chk--;
                check("valid_code", int'(key_code), e);
            end
        end
    end

    function automatic void model_reset();
        mode  = 0;
        mcol  = 0;
        mrow  = 0;
        mcnt  = 0;
        mcode = 0;
    endfunction

    // one scan sample of the pad as the active column sees it
    function automatic void model_tick();
        logic [3:0] rs;
        for (int r = 0; r < 4; r++) rs[r] = !pad[r*4+mcol];
        case (mode)
            0: begin
                if (rs == 4'hF) begin
                    mcol = (mcol + 1) % 4;
                end else begin
                    for (int r = 3; r >= 0; r--) if (!rs[r]) mrow = r;
                    mcnt = 1;
                    mode = 1;
                end
            end
            1: begin
                if (!rs[mrow]) begin
                    mcnt++;
                    if (mcnt == DT) begin
                        mcode = km[mrow*4+mcol];
                        q.push_back(mcode);
                        mode = 2;
                    end
                end else begin
                    mode = 0;
                    mcol = (mcol + 1) % 4;
                end
            end
            2: begin
                if (rs[mrow]) begin
                    mcnt = 1;
                    mode = 3;
                end
            end
            default: begin
                if (!rs[mrow]) begin
                    mode = 2;
                end else begin
                    mcnt++;
                    if (mcnt == DT) begin
                        mode = 0;
                        mcol = (mcol + 1) % 4;
                    end
                end
            end
        endcase
    endfunction

    task automatic tick_period(input logic [15:0] padv);
        scan_clk = ~scan_clk;
        @(posedge clk);
        #1;
        model_tick();
        check("cols", int'(cols), int'(~(4'b0001 << mcol) & 4'hF));
        check("key_held", int'(key_held), int'(mode >= 2));
        check("key_code", int'(key_code), mcode);
        repeat (3) @(posedge clk);
        #1;
        pad = padv;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        scan_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cols", int'(cols), 4'b1110);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_code", int'(key_code), 0);
        model_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [15:0] padv, input int n);
        for (int i = 0; i < n; i++) tick_period(padv);
    endtask

    function automatic logic [15:0] rand_pad();
        int k;
        k = $urandom_range(0, 99);
        if (k < 40) return 16'h0;
        if (k < 85) return 16'h1 << $urandom_range(0, 15);
        return (16'h1 << $urandom_range(0, 15)) |
               (16'h1 << $urandom_range(0, 15));
    endfunction

    initial begin
        logic [15:0] p;
        reset    = 1'b0;
        scan_clk = 1'b0;
        pad      = 16'h0;
        model_reset();
        apply_reset();

        hold(16'h0, 6);
        hold(16'h0020, 10);
        hold(16'h0, 6);
        hold(16'h0008, 2);
        hold(16'h0, 6);
        hold(16'h8000, 10);
        hold(16'h0, 2);
        hold(16'h8000, 3);
        hold(16'h0, 6);
        hold(16'h0110, 10);
        hold(16'h0510, 4);
        hold(16'h0, 6);
        hold(16'h0001, 6);
        apply_reset();
        hold(16'h0001, 8);
        hold(16'h0, 6);

        p = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 25) p = rand_pad();
            if ($urandom_range(0, 99) < 3) apply_reset();
            else tick_period(p);
        end
        hold(16'h0, 8);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
